pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline (F, D, E, M, W).
- Combines four stall sources into per-stage register enables and bubble-inserts:
  - load-use stall from decode hazard detection
  - multi-cycle mul/div in E
  - data-memory wait states in M
  - instruction-memory wait states in F
- Also sequences PC redirects for branches/jumps resolved in E, tracks fetches on the wrong path, and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_pkg.sv | 38 +++
 rtl/pipeline_ctrl_if.sv | 44 ++++
 rtl/pipeline_ctrl_sat_counter.sv | 27 ++
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and defaults for the pipeline stall/flush controller
package pipeline_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        CTRL_RUN,
        CTRL_MD_BUSY
    } ctrl_state_e;

    // Per-stage control word produced every cycle by the sequencer.
    typedef struct packed {
        logic en_f;
        logic en_d;
        logic en_e;
        logic en_m;
        logic bubble_d;
        logic bubble_e;
        logic bubble_m;
        logic bubble_w;
        logic pc_redirect;
    } stage_ctrl_t;

    // Free-running pipeline: everything advances, nothing is squashed.
    localparam stage_ctrl_t STAGE_CTRL_DEFAULT = '{
        en_f:        1'b1,
        en_d:        1'b1,
        en_e:        1'b1,
        en_m:        1'b1,
        bubble_d:    1'b0,
        bubble_e:    1'b0,
        bubble_m:    1'b0,
        bubble_w:    1'b0,
        pc_redirect: 1'b0
    };

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stage-control outputs between datapath and sequencer
//
// master: the stall/flush sequencer (consumes hazards, drives enables/bubbles)
// slave : the pipeline datapath (drives hazards, consumes enables/bubbles)
interface pipeline_ctrl_if #(
    parameter int XLEN = pipeline_pkg::XLEN_DEF
);
    logic            load_use;
    logic            md_op_e;
    logic            md_done;
    logic            md_start;
    logic            dmem_req_m;
    logic            dmem_ready;
    logic            imem_ready;
    logic            redirect_e;
    logic [XLEN-1:0] redirect_pc_e;
    logic            pc_redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            en_f;
    logic            en_d;
    logic            en_e;
    logic            en_m;
    logic            bubble_d;
    logic            bubble_e;
    logic            bubble_m;
    logic            bubble_w;

    modport master (
        input  load_use, md_op_e, md_done, dmem_req_m, dmem_ready,
               imem_ready, redirect_e, redirect_pc_e,
        output md_start, pc_redirect, redirect_pc,
               en_f, en_d, en_e, en_m,
               bubble_d, bubble_e, bubble_m, bubble_w
    );

    modport slave (
        output load_use, md_op_e, md_done, dmem_req_m, dmem_ready,
               imem_ready, redirect_e, redirect_pc_e,
        input  md_start, pc_redirect, redirect_pc,
               en_f, en_d, en_e, en_m,
               bubble_d, bubble_e, bubble_m, bubble_w
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating event counter with synchronous clear
//
// clk, rst_n : clock, asynchronous active-low reset
// inc        : count this cycle
// clr        : synchronous clear, wins over inc
// count      : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage F/D/E/M/W pipeline
//
// clk, rst_n : clock, asynchronous active-low reset
// bus        : hazard inputs, mul/div handshake, redirect, stage enables/bubbles
// cnt_clr    : synchronous clear of both performance counters
// stall_cnt  : saturating count of cycles with en_f=0
// flush_cnt  : saturating count of redirects taken
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.master  bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_e state, state_d;
    logic        md_done_q, md_done_q_d;
    logic        discard, discard_d;

    logic        mem_wait;
    logic        md_done_any;
    logic        md_fire;
    logic        md_hold;
    logic        md_start;
    stage_ctrl_t ctrl;
    logic [XLEN-1:0] target;

    assign mem_wait    = bus.dmem_req_m & ~bus.dmem_ready;
    assign md_done_any = bus.md_done | md_done_q;
    // A data-memory stall freezes E too, so a mul/div cannot be launched under it.
    assign md_fire     = (state == CTRL_RUN) & bus.md_op_e & ~mem_wait;
    assign md_hold     = md_fire | ((state == CTRL_MD_BUSY) & ~md_done_any);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CTRL_RUN;
            md_done_q <= 1'b0;
            discard   <= 1'b0;
        end else begin
            state     <= state_d;
            md_done_q <= md_done_q_d;
            discard   <= discard_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state;
        md_done_q_d = md_done_q;
        case (state)
            CTRL_RUN: begin
                if (md_fire) begin
                    state_d = CTRL_MD_BUSY;
                end
            end
            CTRL_MD_BUSY: begin
                if (md_done_any && !mem_wait) begin
                    state_d     = CTRL_RUN;
                    md_done_q_d = 1'b0;
                end else if (bus.md_done && mem_wait) begin
                    // Result pulse landed while E is frozen; remember it.
                    md_done_q_d = 1'b1;
                end
            end
            default: begin
                state_d     = CTRL_RUN;
                md_done_q_d = 1'b0;
            end
        endcase

        // A wrong-path fetch is outstanding from a redirect until imem answers.
        // If imem answers in the redirect cycle itself, nothing is left in flight.
        discard_d = ~bus.imem_ready & (ctrl.pc_redirect | discard);
    end

    // Output logic
    always_comb begin
        ctrl = STAGE_CTRL_DEFAULT;
        if (mem_wait) begin
            ctrl.en_f     = 1'b0;
            ctrl.en_d     = 1'b0;
            ctrl.en_e     = 1'b0;
            ctrl.en_m     = 1'b0;
            ctrl.bubble_w = 1'b1;
        end else if (md_hold) begin
            ctrl.en_f     = 1'b0;
            ctrl.en_d     = 1'b0;
            ctrl.en_e     = 1'b0;
            ctrl.bubble_m = 1'b1;
        end else if (bus.redirect_e) begin
            // D holds a wrong-path instruction, so its load-use stall is moot.
            ctrl.pc_redirect = 1'b1;
            ctrl.bubble_d    = 1'b1;
            ctrl.bubble_e    = 1'b1;
        end else if (bus.load_use) begin
            ctrl.en_f     = 1'b0;
            ctrl.en_d     = 1'b0;
            ctrl.bubble_e = 1'b1;
        end else if (!bus.imem_ready || discard) begin
            // PC holds only while the fetch is pending; a returning
            // wrong-path instruction is dropped by bubbling D.
            ctrl.en_f     = bus.imem_ready;
            ctrl.bubble_d = 1'b1;
        end
        md_start = md_fire & rst_n;
    end

    assign target          = bus.redirect_pc_e;
    assign bus.redirect_pc = target;
    assign bus.md_start    = md_start;
    assign bus.pc_redirect = ctrl.pc_redirect;
    assign bus.en_f        = ctrl.en_f;
    assign bus.en_d        = ctrl.en_d;
    assign bus.en_e        = ctrl.en_e;
    assign bus.en_m        = ctrl.en_m;
    assign bus.bubble_d    = ctrl.bubble_d;
    assign bus.bubble_e    = ctrl.bubble_e;
    assign bus.bubble_m    = ctrl.bubble_m;
    assign bus.bubble_w    = ctrl.bubble_w;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl.en_f),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl.pc_redirect),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    // {load_use, md_op_e, md_done, dmem_req_m, dmem_ready, imem_ready, redirect_e}
    typedef logic [6:0] in_t;
    // {en_f, en_d, en_e, en_m, bubble_d, bubble_e, bubble_m, bubble_w, pc_redirect, md_start}
    typedef logic [9:0] out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  e;
    } vec_t;

    localparam in_t I_IDLE    = 7'b0000010;
    localparam in_t I_LU      = 7'b1000010;
    localparam in_t I_MW      = 7'b0001010;
    localparam in_t I_MD      = 7'b0100010;
    localparam in_t I_MD_DONE = 7'b0110010;
    localparam in_t I_MD_MWD  = 7'b0111010;
    localparam in_t I_MD_MW   = 7'b0101010;
    localparam in_t I_MD_RDY  = 7'b0101110;
    localparam in_t I_RED_LU0 = 7'b1000001;
    localparam in_t I_RED_I0  = 7'b0000001;
    localparam in_t I_I0      = 7'b0000000;
    localparam in_t I_RED_I1  = 7'b0000011;

    localparam out_t O_IDLE = 10'b1111_0000_00;
    localparam out_t O_LU   = 10'b0011_0100_00;
    localparam out_t O_MW   = 10'b0000_0001_00;
    localparam out_t O_RED  = 10'b1111_1100_10;
    localparam out_t O_I0   = 10'b0111_1000_00;
    localparam out_t O_DISC = 10'b1111_1000_00;
    localparam out_t O_FIRE = 10'b0001_0010_01;
    localparam out_t O_MDH  = 10'b0001_0010_00;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_vec;
    int n_err;
    logic [CNT_W-1:0] m_stall;
    logic [CNT_W-1:0] m_flush;
    out_t exp_q[$];
    vec_t vecs[$];

    pipeline_ctrl_if #(.XLEN(32)) bus ();

    pipeline_ctrl #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t actual();
        return {bus.en_f, bus.en_d, bus.en_e, bus.en_m,
                bus.bubble_d, bus.bubble_e, bus.bubble_m, bus.bubble_w,
                bus.pc_redirect, bus.md_start};
    endfunction

    task automatic drive(input in_t i);
        {bus.load_use, bus.md_op_e, bus.md_done, bus.dmem_req_m,
         bus.dmem_ready, bus.imem_ready, bus.redirect_e} = i;
    endtask

    task automatic check_cnt(input string name);
        n_vec++;
        if (stall_cnt !== m_stall) begin
            n_err++;
            $display("FAIL %s stall_cnt got=%0d want=%0d", name, stall_cnt, m_stall);
        end
        n_vec++;
        if (flush_cnt !== m_flush) begin
            n_err++;
            $display("FAIL %s flush_cnt got=%0d want=%0d", name, flush_cnt, m_flush);
        end
    endtask

    // One clock: drive at negedge, compare controls mid-cycle, counters after the edge.
    task automatic step(input string name, input in_t i, input out_t e, input logic clr);
        logic [31:0] pc;
        out_t got;
        out_t want;
        @(negedge clk);
        pc = $urandom;
        drive(i);
        bus.redirect_pc_e = pc;
        cnt_clr = clr;
        exp_q.push_back(e);
        #2;
        got  = actual();
        want = exp_q.pop_front();
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s ctrl got=%b want=%b", name, got, want);
        end
        n_vec++;
        if (bus.redirect_pc !== pc) begin
            n_err++;
            $display("FAIL %s redirect_pc got=%h want=%h", name, bus.redirect_pc, pc);
        end
        if (clr) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!want[9] && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
            if (want[1] && m_flush != {CNT_W{1'b1}}) m_flush = m_flush + 1'b1;
        end
        @(posedge clk);
        #1;
        check_cnt(name);
        cnt_clr = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_stall = '0;
        m_flush = '0;
        cnt_clr = 1'b0;
        bus.redirect_pc_e = 32'h0;
        rst_n = 1'b0;
        drive(I_MD);
        #2;
        n_vec++;
        if (bus.md_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset md_start got=%b want=0", bus.md_start);
        end
        check_cnt("reset");
        @(negedge clk);
        drive(I_IDLE);
        rst_n = 1'b1;

        // Single-cycle priority table, all from RUN with no fetch in flight.
        vecs.push_back('{"idle",          I_IDLE,        O_IDLE});
        vecs.push_back('{"load_use",      I_LU,          O_LU});
        vecs.push_back('{"mem_wait",      I_MW,          O_MW});
        vecs.push_back('{"mw_over_all",   7'b1001011,    O_MW});
        vecs.push_back('{"mem_done_lu",   7'b1001110,    O_LU});
        vecs.push_back('{"red_over_lu",   7'b1000011,    O_RED});
        vecs.push_back('{"imem_wait",     I_I0,          O_I0});
        vecs.push_back('{"lu_over_imem",  7'b1000000,    O_LU});
        vecs.push_back('{"md_under_mw",   I_MD_MW,       O_MW});
        vecs.push_back('{"red_under_mw",  7'b0001001,    O_MW});
        vecs.push_back('{"idle_after",    I_IDLE,        O_IDLE});
        foreach (vecs[k]) step(vecs[k].name, vecs[k].i, vecs[k].e, 1'b0);

        // Mul/div, result after 4 cycles.
        step("md_fire",  I_MD,      O_FIRE, 1'b1);
        for (int c = 1; c <= 3; c++) step("md_busy", I_MD, O_MDH, 1'b0);
        step("md_done",  I_MD_DONE, O_IDLE, 1'b0);
        step("md_run",   I_IDLE,    O_IDLE, 1'b0);

        // md_done arrives while M is waiting on memory.
        step("mdq_fire",  I_MD,     O_FIRE, 1'b0);
        step("mdq_done",  I_MD_MWD, O_MW,   1'b0);
        step("mdq_wait",  I_MD_MW,  O_MW,   1'b0);
        step("mdq_exit",  I_MD_RDY, O_IDLE, 1'b0);
        step("mdq_run",   I_IDLE,   O_IDLE, 1'b0);

        // Wrong-path fetch dropped on arrival.
        step("wp_red",    I_RED_LU0, O_RED,  1'b0);
        step("wp_pend",   I_I0,      O_I0,   1'b0);
        step("wp_arrive", I_IDLE,    O_DISC, 1'b0);
        step("wp_clean",  I_IDLE,    O_IDLE, 1'b0);

        // Second redirect while the wrong-path fetch is still pending.
        step("wp2_red",    I_RED_I0, O_RED,  1'b0);
        step("wp2_red2",   I_RED_I0, O_RED,  1'b0);
        step("wp2_arrive", I_IDLE,   O_DISC, 1'b0);
        step("wp2_clean",  I_IDLE,   O_IDLE, 1'b0);

        // Redirect coinciding with imem arrival leaves nothing to discard.
        step("red_rdy",    I_RED_I1, O_RED,  1'b0);
        step("red_rdy_nx", I_IDLE,   O_IDLE, 1'b0);

        // Stall counter saturation and clear under an ongoing stall.
        step("sat_clr", I_IDLE, O_IDLE, 1'b1);
        for (int c = 0; c < 20; c++) step("sat_mw", I_MW, O_MW, 1'b0);
        step("sat_clr_mw", I_MW, O_MW, 1'b1);
        step("sat_after",  I_MW, O_MW, 1'b0);

        // Reset in the middle of a mul/div.
        step("rst_fire", I_MD, O_FIRE, 1'b0);
        step("rst_busy", I_MD, O_MDH,  1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        m_stall = '0;
        m_flush = '0;
        n_vec++;
        if (bus.md_start !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid md_start got=%b want=0", bus.md_start);
        end
        check_cnt("rst_mid");
        @(negedge clk);
        drive(I_IDLE);
        rst_n = 1'b1;
        step("rst_idle",  I_IDLE,    O_IDLE, 1'b0);
        step("rst_fire2", I_MD,      O_FIRE, 1'b0);
        step("rst_done2", I_MD_DONE, O_IDLE, 1'b0);
        step("rst_end",   I_IDLE,    O_IDLE, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
